// File: rtl/hqc_rs_pkg.sv
// Shared constants for the HQC Reed-Solomon parity generator: code sizes per parameter set,
// GF(2^8) arithmetic over x^8+x^4+x^3+x^2+1 and the generator polynomials derived from it.
package hqc_rs_pkg;

  localparam int N1_BYTES_128 = 46;
  localparam int K_BYTES_128  = 16;
  localparam int N1_BYTES_192 = 56;
  localparam int K_BYTES_192  = 24;
  localparam int N1_BYTES_256 = 90;
  localparam int K_BYTES_256  = 32;

  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam int         MAX_PAR = N1_BYTES_256 - K_BYTES_256;

  typedef logic [MAX_PAR-1:0][7:0] rs_gvec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    FIN    = 2'd2,
    DRAIN  = 2'd3
  } rs_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; with one operand constant this folds to a pure XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // g(x) = prod_{i=1..par} (x - alpha^i), alpha = 0x02; monic term dropped from the result.
  function automatic rs_gvec_t gen_poly(input int par);
    logic [MAX_PAR:0][7:0] g;
    logic [7:0]            root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 1; i <= par; i++) begin
      root = gf_xtime(root);
      for (int j = i; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
    end
    return g[MAX_PAR-1:0];
  endfunction

  localparam rs_gvec_t RS_G_128 = gen_poly(N1_BYTES_128 - K_BYTES_128);
  localparam rs_gvec_t RS_G_192 = gen_poly(N1_BYTES_192 - K_BYTES_192);
  localparam rs_gvec_t RS_G_256 = gen_poly(N1_BYTES_256 - K_BYTES_256);

  function automatic int n1_of(input string ps);
    if (ps == "hqc192") return N1_BYTES_192;
    if (ps == "hqc256") return N1_BYTES_256;
    return N1_BYTES_128;
  endfunction

  function automatic int k_of(input string ps);
    if (ps == "hqc192") return K_BYTES_192;
    if (ps == "hqc256") return K_BYTES_256;
    return K_BYTES_128;
  endfunction

  function automatic rs_gvec_t gen_of(input string ps);
    if (ps == "hqc192") return RS_G_192;
    if (ps == "hqc256") return RS_G_256;
    return RS_G_128;
  endfunction

endpackage

// File: rtl/rs_enc_lfsr_seq_gf256_const_mul.sv
// Combinational GF(2^8) multiply by a constant coefficient (XOR network, no tables).
module gf256_const_mul
  import hqc_rs_pkg::*;
#(
  parameter logic [7:0] COEF = 8'h01
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = gf_mul(din, COEF);

endmodule

// File: rtl/rs_enc_lfsr_seq.sv
// Byte-serial systematic RS parity LFSR for HQC. Optional serial parity drain port
// enabled by defining RS_ENC_STREAM_OUT_EN.
module rs_enc_lfsr_seq
  import hqc_rs_pkg::*;
#(
  parameter  string parameter_set = "hqc128",
  localparam int    N1_BYTES      = n1_of(parameter_set),
  localparam int    K_BYTES       = k_of(parameter_set),
  localparam int    PAR_BYTES     = N1_BYTES - K_BYTES,
  localparam int    CNT_W         = $clog2(K_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             msg_in,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  output logic [8*PAR_BYTES-1:0] parity_out,
  output logic                   busy,
`ifdef RS_ENC_STREAM_OUT_EN
  output logic [7:0]             par_byte,
  output logic                   par_valid,
  input  logic                   par_ready,
`endif
  output logic                   done
);

  localparam rs_gvec_t G_VEC = gen_of(parameter_set);

  rs_state_e                   state_q, state_d;
  logic [PAR_BYTES-1:0][7:0]   lfsr_q, lfsr_d;
  logic [PAR_BYTES-1:0][7:0]   tmp;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [7:0]                  gate;

  // Feedback byte: incoming symbol folded with the LFSR's top byte.
  assign gate = msg_in ^ lfsr_q[PAR_BYTES-1];

  for (genvar j = 0; j < PAR_BYTES; j++) begin : g_mul
    gf256_const_mul #(.COEF(G_VEC[j])) u_mul (
      .din  (gate),
      .dout (tmp[j])
    );
  end

`ifdef RS_ENC_STREAM_OUT_EN
  localparam int DIDX_W = (PAR_BYTES > 1) ? $clog2(PAR_BYTES) : 1;
  logic [DIDX_W-1:0] didx_q, didx_d;
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
`ifdef RS_ENC_STREAM_OUT_EN
    didx_d  = didx_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ABSORB;
          lfsr_d  = '0;
          cnt_d   = '0;
        end
      end
      ABSORB: begin
        if (msg_valid) begin
          lfsr_d[0] = tmp[0];
          for (int j = 1; j < PAR_BYTES; j++) lfsr_d[j] = lfsr_q[j-1] ^ tmp[j];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(K_BYTES - 1)) state_d = FIN;
        end
      end
      FIN: begin
`ifdef RS_ENC_STREAM_OUT_EN
        state_d = DRAIN;
        didx_d  = DIDX_W'(PAR_BYTES - 1);
`else
        state_d = IDLE;
`endif
      end
`ifdef RS_ENC_STREAM_OUT_EN
      DRAIN: begin
        // Highest-order parity byte leaves first.
        if (par_ready) begin
          if (didx_q == '0) state_d = IDLE;
          else              didx_d  = didx_q - DIDX_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RS_ENC_STREAM_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) didx_q <= '0;
    else        didx_q <= didx_d;
  end

  assign par_valid = (state_q == DRAIN);
  assign par_byte  = lfsr_q[didx_q];
`endif

  // Ready decodes the state register only, so it never depends on msg_valid.
  assign msg_ready  = (state_q == ABSORB);
  assign done       = (state_q == FIN);
  assign parity_out = lfsr_q;
`ifdef RS_ENC_STREAM_OUT_EN
  assign busy = (state_q == ABSORB) || (state_q == DRAIN) || ((state_q == IDLE) && start);
`else
  assign busy = (state_q == ABSORB) || ((state_q == IDLE) && start);
`endif

endmodule

// File: tb/tb_rs_enc_lfsr_seq.sv
// Bench for rs_enc_lfsr_seq: three parameter sets, reference parity by polynomial long division.
module tb_rs_enc_lfsr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0]      st, vld;
  logic [2:0][7:0] din;
  wire  [2:0]      rdy, bsy, dn;
  wire  [239:0]    p0;
  wire  [255:0]    p1;
  wire  [463:0]    p2;
`ifdef RS_ENC_STREAM_OUT_EN
  wire  [2:0][7:0] pb;
  wire  [2:0]      pv;
  logic            pr0;
`endif

  rs_enc_lfsr_seq #(.parameter_set("hqc128")) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .msg_in(din[0]), .msg_valid(vld[0]),
    .msg_ready(rdy[0]), .parity_out(p0), .busy(bsy[0]),
`ifdef RS_ENC_STREAM_OUT_EN
    .par_byte(pb[0]), .par_valid(pv[0]), .par_ready(pr0),
`endif
    .done(dn[0]));

  rs_enc_lfsr_seq #(.parameter_set("hqc192")) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .msg_in(din[1]), .msg_valid(vld[1]),
    .msg_ready(rdy[1]), .parity_out(p1), .busy(bsy[1]),
`ifdef RS_ENC_STREAM_OUT_EN
    .par_byte(pb[1]), .par_valid(pv[1]), .par_ready(1'b1),
`endif
    .done(dn[1]));

  rs_enc_lfsr_seq #(.parameter_set("hqc256")) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .msg_in(din[2]), .msg_valid(vld[2]),
    .msg_ready(rdy[2]), .parity_out(p2), .busy(bsy[2]),
`ifdef RS_ENC_STREAM_OUT_EN
    .par_byte(pb[2]), .par_valid(pv[2]), .par_ready(1'b1),
`endif
    .done(dn[2]));

  int checks = 0;
  int errors = 0;
  int KS[3] = '{16, 24, 32};
  int PS[3] = '{30, 32, 58};

  logic [7:0] gexp [0:254];
  int         glog [0:255];
  logic [7:0] gb   [3][0:58];

  // Monitors: busy cycle count on dut0, ready-outside-busy violations, drained bytes.
  int busy_cnt = 0;
  int rdy_viol = 0;
  always @(negedge clk) begin
    if (bsy[0]) busy_cnt++;
    for (int i = 0; i < 3; i++) if (rdy[i] && !bsy[i]) rdy_viol++;
  end

`ifdef RS_ENC_STREAM_OUT_EN
  logic [7:0] dlog [0:1023];
  int         drn_cnt = 0;
  always @(posedge clk) begin
    if (pv[0] && pr0) begin
      dlog[drn_cnt % 1024] <= pb[0];
      drn_cnt <= drn_cnt + 1;
    end
  end
`endif

  task automatic chk(input string nm, input logic [463:0] act, input logic [463:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  function automatic logic [463:0] parity_of(input int d);
    case (d)
      0:       return {224'h0, p0};
      1:       return {208'h0, p1};
      default: return p2;
    endcase
  endfunction

  // Remainder of m(x)*x^p divided by g(x), done as schoolbook long division.
  function automatic logic [463:0] model(input int d, input logic [31:0][7:0] m);
    logic [7:0]   dv [0:89];
    logic [7:0]   c;
    logic [463:0] r;
    int k, p;
    k = KS[d];
    p = PS[d];
    for (int i = 0; i < 90; i++) dv[i] = 8'h00;
    for (int i = 0; i < k; i++) dv[p+i] = m[i];
    for (int deg = p + k - 1; deg >= p; deg--) begin
      c = dv[deg];
      for (int j = 0; j <= p; j++) dv[deg-p+j] = dv[deg-p+j] ^ mul(c, gb[d][j]);
    end
    r = '0;
    for (int j = 0; j < p; j++) r[8*j +: 8] = dv[j];
    return r;
  endfunction

  function automatic logic [463:0] gen_vec(input int d);
    logic [463:0] r;
    r = '0;
    for (int j = 0; j < PS[d]; j++) r[8*j +: 8] = gb[d][j];
    return r;
  endfunction

  function automatic logic [31:0][7:0] rnd_msg(input int d);
    logic [31:0][7:0] m;
    m = '0;
    for (int i = 0; i < KS[d]; i++) m[i] = 8'($urandom_range(0, 255));
    return m;
  endfunction

  // Feeds msg[k-1] first. sat>=0 pulses start while that many bytes have been taken;
  // junk drives a byte together with start; tog toggles par_ready and pokes start in DRAIN.
  task automatic run(input int d, input logic [31:0][7:0] m, input int stall, input int sat,
                     input bit junk, input bit tog, output logic [463:0] par);
    int k, acc, cyc;
    k = KS[d];
    st[d] = 1'b1;
    if (junk) begin
      vld[d] = 1'b1;
      din[d] = 8'h5A;
    end
    @(negedge clk);
    if (junk) chk($sformatf("rdy_in_idle_d%0d", d), {463'h0, rdy[d]}, 464'h0);
    @(posedge clk); #1;
    st[d]  = 1'b0;
    vld[d] = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < k && cyc < 4000) begin
      vld[d] = (stall == 0) || ($urandom_range(0, 99) >= stall);
      din[d] = m[k-1-acc];
      st[d]  = (sat >= 0) && (acc == sat);
      @(negedge clk);
      if (vld[d] && rdy[d]) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    vld[d] = 1'b0;
    st[d]  = 1'b0;
    if (acc < k) chk($sformatf("accept_timeout_d%0d", d), 464'(acc), 464'(k));
    @(negedge clk);
    chk($sformatf("done_latency_d%0d", d), {463'h0, dn[d]}, 464'h1);
    par = parity_of(d);
    @(posedge clk); #1;
    chk($sformatf("done_pulse_d%0d", d), {463'h0, dn[d]}, 464'h0);
`ifdef RS_ENC_STREAM_OUT_EN
    cyc = 0;
    while (bsy[d] && cyc < 500) begin
      if (tog && d == 0) pr0 = ~pr0;
      st[d] = tog && (cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    st[d] = 1'b0;
    pr0   = 1'b1;
    if (cyc >= 500) chk($sformatf("drain_timeout_d%0d", d), 464'(cyc), 464'h0);
`else
    if (tog) chk("tog_without_stream", 464'h1, {463'h0, bsy[d]});
`endif
    chk($sformatf("parity_hold_d%0d", d), parity_of(d), par);
  endtask

  typedef struct {
    int               d;
    logic [31:0][7:0] m;
    int               stall;
    int               sat;
    bit               junk;
    logic [463:0]     exp;
  } vec_t;

  vec_t             tv [10];
  logic [463:0]     got, pa, pbb, pab;
  logic [31:0][7:0] ma, mb, mu;
  int               base, x, exp_busy;

  initial begin
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x[7:0];
      glog[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    glog[0] = 0;
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j <= 58; j++) gb[d][j] = 8'h00;
      gb[d][0] = 8'h01;
      for (int i = 1; i <= PS[d]; i++)
        for (int j = i; j >= 0; j--)
          gb[d][j] = ((j > 0) ? gb[d][j-1] : 8'h00) ^ mul(gb[d][j], gexp[i]);
    end

    mu = '0;
    mu[0] = 8'h01;
    tv[0] = '{0, '0, 0, -1, 1'b0, '0};
    tv[1] = '{0, mu, 0, -1, 1'b0, gen_vec(0)};
    tv[2] = '{1, mu, 0, -1, 1'b0, gen_vec(1)};
    tv[3] = '{2, mu, 0, -1, 1'b0, gen_vec(2)};
    tv[4] = '{0, rnd_msg(0), 40, -1, 1'b0, '0};
    tv[5] = '{0, rnd_msg(0), 20, 5, 1'b0, '0};
    tv[6] = '{0, rnd_msg(0), 0, -1, 1'b1, '0};
    tv[7] = '{1, rnd_msg(1), 30, -1, 1'b0, '0};
    tv[8] = '{2, rnd_msg(2), 30, -1, 1'b0, '0};
    tv[9] = '{0, {16{8'hFF}}, 0, -1, 1'b0, '0};
    for (int i = 4; i < 10; i++) tv[i].exp = model(tv[i].d, tv[i].m);

    rst_n = 1'b0;
    st    = '0;
    vld   = '0;
    din   = '0;
`ifdef RS_ENC_STREAM_OUT_EN
    pr0   = 1'b1;
`endif
    #3;
    chk("reset_outputs", {p2, p1, p0, rdy, bsy, dn}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      base = busy_cnt;
      run(tv[i].d, tv[i].m, tv[i].stall, tv[i].sat, tv[i].junk, 1'b0, got);
      chk($sformatf("vec%0d_parity", i), got, tv[i].exp);
      if (i == 0) begin
`ifdef RS_ENC_STREAM_OUT_EN
        exp_busy = 17 + 30;
`else
        exp_busy = 17;
`endif
        chk("zero_msg_busy_cycles", 464'(busy_cnt - base), 464'(exp_busy));
      end
      repeat (2) @(posedge clk);
      #1;
    end

    for (int r = 0; r < 3; r++) begin
      ma = rnd_msg(0);
      mb = rnd_msg(0);
      run(0, ma, 50, -1, 1'b0, 1'b0, pa);
      run(0, mb, 50, -1, 1'b0, 1'b0, pbb);
      run(0, ma ^ mb, 50, -1, 1'b0, 1'b0, pab);
      chk($sformatf("lin%0d_a", r), pa, model(0, ma));
      chk($sformatf("lin%0d_b", r), pbb, model(0, mb));
      chk($sformatf("lin%0d_xor", r), pa ^ pbb, pab);
    end

    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      vld[0] = 1'b1;
      din[0] = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    vld[0] = 1'b0;
    chk("busy_before_reset", {463'h0, bsy[0]}, 464'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {224'h0, p0, rdy[0], bsy[0], dn[0]}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    ma = rnd_msg(0);
    run(0, ma, 25, -1, 1'b0, 1'b0, got);
    chk("after_reset_parity", got, model(0, ma));

`ifdef RS_ENC_STREAM_OUT_EN
    base = drn_cnt;
    run(0, mu, 0, -1, 1'b0, 1'b1, got);
    chk("drain_count", 464'(drn_cnt - base), 464'd30);
    chk("drain_busy_low", {463'h0, bsy[0]}, 464'h0);
    for (int j = 0; j < 30; j++)
      chk($sformatf("drain_byte%0d", j), {456'h0, dlog[(base + j) % 1024]}, {456'h0, gb[0][29-j]});
`endif

    chk("ready_outside_absorb", 464'(rdy_viol), 464'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
